pci_target: RTL and testbench

Responder end of the shared PCI-style bus: claims transactions whose address phase matches `DEV_ADDR`, then serves a burst of reads from, or accepts a burst of writes into, a small internal word memory. Uses the same single-bit read/write command and active-low FRAME/IRDY/TRDY/DEVSEL handshake as the bus initiator. The bus itself is resolved at the device top level: this block sees `ad_in` and drives `ad_out` qualified by `ad_oe`.

---
 rtl/pci_target.sv | 172 +++++++++++++++++
 tb/tb_pci_target.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pci_target.sv
// PCI-style bus target: claims address phases matching DEV_ADDR and serves read or write
// bursts from a small word memory, with a target disconnect when the memory runs out.
module pci_target #(
   parameter logic [31:0] DEV_ADDR = 32'h0000_0001,
   parameter int unsigned DEPTH    = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_n,
   input  logic        irdy_n,
   input  logic        cbe,
   input  logic [31:0] ad_in,
   output logic [31:0] ad_out,
   output logic        ad_oe,
   output logic        trdy_n,
   output logic        devsel_n,
   output logic        stop_n,
   output logic [3:0]  data_count
);

   localparam int unsigned AddrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]  LastIdx = 4'(DEPTH - 1);

   typedef enum logic [2:0] {StIdle, StTurn, StData, StStop, StIgnore} state_e;

   state_e      state_q, state_d;
   logic        is_read_q, is_read_d;
   logic [3:0]  idx_q, idx_d;
   logic        trdy_n_q, trdy_n_d;
   logic        devsel_n_q, devsel_n_d;
   logic        stop_n_q, stop_n_d;
   logic        ad_oe_q, ad_oe_d;
   logic [31:0] ad_out_q, ad_out_d;
   logic [31:0] mem_q [DEPTH];

   logic             mem_we;
   logic [AddrW-1:0] mem_waddr;
   logic [3:0]       idx_inc;
   logic             addr_hit;
   logic             complete;
   logic             abort;

   assign addr_hit = (ad_in == DEV_ADDR);
   assign complete = !irdy_n && !trdy_n_q;
   assign abort    = frame_n && irdy_n;
   assign idx_inc  = idx_q + 4'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         is_read_q  <= 1'b0;
         idx_q      <= 4'd0;
         trdy_n_q   <= 1'b1;
         devsel_n_q <= 1'b1;
         stop_n_q   <= 1'b1;
         ad_oe_q    <= 1'b0;
         ad_out_q   <= 32'd0;
      end else begin
         state_q    <= state_d;
         is_read_q  <= is_read_d;
         idx_q      <= idx_d;
         trdy_n_q   <= trdy_n_d;
         devsel_n_q <= devsel_n_d;
         stop_n_q   <= stop_n_d;
         ad_oe_q    <= ad_oe_d;
         ad_out_q   <= ad_out_d;
      end
   end

   // Memory has no reset; a reset edge still suppresses the write it coincides with.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         mem_q[mem_waddr] <= ad_in;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (!frame_n) begin
               if (addr_hit) state_d = cbe ? StTurn : StData;
               else          state_d = StIgnore;
            end
         end
         StIgnore: if (abort) state_d = StIdle;
         StTurn:   state_d = abort ? StIdle : StData;
         StData: begin
            if (abort) begin
               state_d = StIdle;
            end else if (complete) begin
               if (frame_n)               state_d = StIdle;
               else if (idx_q == LastIdx) state_d = StStop;
            end
         end
         StStop:   if (frame_n) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      is_read_d  = is_read_q;
      idx_d      = idx_q;
      trdy_n_d   = trdy_n_q;
      devsel_n_d = devsel_n_q;
      stop_n_d   = stop_n_q;
      ad_oe_d    = ad_oe_q;
      ad_out_d   = ad_out_q;
      mem_we     = 1'b0;
      mem_waddr  = idx_q[AddrW-1:0];
      case (state_q)
         StIdle: begin
            if (!frame_n && addr_hit) begin
               is_read_d  = cbe;
               idx_d      = 4'd0;
               devsel_n_d = 1'b0;
               trdy_n_d   = cbe;
            end
         end
         StTurn: begin
            if (abort) begin
               trdy_n_d   = 1'b1;
               devsel_n_d = 1'b1;
               ad_oe_d    = 1'b0;
            end else begin
               trdy_n_d = 1'b0;
               ad_oe_d  = 1'b1;
               ad_out_d = mem_q[0];
            end
         end
         StData: begin
            if (abort) begin
               trdy_n_d   = 1'b1;
               devsel_n_d = 1'b1;
               ad_oe_d    = 1'b0;
            end else if (complete) begin
               idx_d = idx_inc;
               if (is_read_q) begin
                  // Prefetch the next word; past the last word there is nothing to fetch.
                  if (idx_q != LastIdx) ad_out_d = mem_q[idx_inc[AddrW-1:0]];
               end else begin
                  mem_we = 1'b1;
               end
               if (frame_n) begin
                  trdy_n_d   = 1'b1;
                  devsel_n_d = 1'b1;
                  ad_oe_d    = 1'b0;
               end else if (idx_q == LastIdx) begin
                  trdy_n_d = 1'b1;
                  stop_n_d = 1'b0;
               end
            end
         end
         StStop: begin
            if (frame_n) begin
               stop_n_d   = 1'b1;
               devsel_n_d = 1'b1;
               ad_oe_d    = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign ad_out     = ad_out_q;
   assign ad_oe      = ad_oe_q;
   assign trdy_n     = trdy_n_q;
   assign devsel_n   = devsel_n_q;
   assign stop_n     = stop_n_q;
   assign data_count = idx_q;

endmodule

// File: tb/tb_pci_target.sv
// Bench for pci_target: directed vector table, hand-written burst/disconnect/reset sequences,
// and randomized transactions checked every cycle against a transaction-level model.
module tb_pci_target;

   localparam int          DEPTH = 10;
   localparam logic [31:0] DEV   = 32'h0000_0001;

   localparam int PhIdle   = 0;
   localparam int PhIgnore = 1;
   localparam int PhTurn   = 2;
   localparam int PhData   = 3;
   localparam int PhStop   = 4;

   logic        clk = 1'b0;
   logic        reset, frame_n, irdy_n, cbe;
   logic [31:0] ad_in, ad_out;
   logic        ad_oe, trdy_n, devsel_n, stop_n;
   logic [3:0]  data_count;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int          m_phase;
   logic        m_read;
   int          m_cnt;
   logic        m_trdy, m_devsel, m_stop, m_oe;
   logic [31:0] m_out;
   logic        m_out_known;
   logic [31:0] m_mem   [DEPTH];
   logic        m_known [DEPTH];

   pci_target #(.DEV_ADDR(DEV), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .frame_n    (frame_n),
      .irdy_n     (irdy_n),
      .cbe        (cbe),
      .ad_in      (ad_in),
      .ad_out     (ad_out),
      .ad_oe      (ad_oe),
      .trdy_n     (trdy_n),
      .devsel_n   (devsel_n),
      .stop_n     (stop_n),
      .data_count (data_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        frame_n;
      logic        irdy_n;
      logic        cbe;
      logic [31:0] ad;
      logic [3:0]  exp_flags;   // {trdy_n, devsel_n, stop_n, ad_oe}
      logic [3:0]  exp_cnt;
      logic        chk_out;
      logic [31:0] exp_out;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic f, input logic i, input logic c, input logic [31:0] a,
                               input logic [3:0] fl, input logic [3:0] cn, input logic ck,
                               input logic [31:0] o);
      vec_t v;
      v.frame_n = f; v.irdy_n = i; v.cbe = c; v.ad = a;
      v.exp_flags = fl; v.exp_cnt = cn; v.chk_out = ck; v.exp_out = o;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_release();
      m_phase  = PhIdle;
      m_trdy   = 1'b1;
      m_devsel = 1'b1;
      m_stop   = 1'b1;
      m_oe     = 1'b0;
   endtask

   // One bus edge, applied from the values the initiator presents at that edge.
   task automatic model_edge();
      logic done;
      if (reset) begin
         model_release();
         m_cnt = 0; m_out = 32'd0; m_out_known = 1'b1; m_read = 1'b0;
         return;
      end
      done = !irdy_n && !m_trdy;
      case (m_phase)
         PhIdle: begin
            if (!frame_n) begin
               if (ad_in == DEV) begin
                  m_read = cbe; m_cnt = 0; m_devsel = 1'b0;
                  if (cbe) m_phase = PhTurn;
                  else begin m_phase = PhData; m_trdy = 1'b0; end
               end else begin
                  m_phase = PhIgnore;
               end
            end
         end
         PhIgnore: if (frame_n && irdy_n) m_phase = PhIdle;
         PhTurn: begin
            if (frame_n && irdy_n) model_release();
            else begin
               m_phase = PhData; m_trdy = 1'b0; m_oe = 1'b1;
               m_out = m_mem[0]; m_out_known = m_known[0];
            end
         end
         PhData: begin
            if (frame_n && irdy_n) begin
               model_release();
            end else if (done) begin
               if (m_read) begin
                  if (m_cnt + 1 < DEPTH) begin
                     m_out = m_mem[4'(m_cnt + 1)]; m_out_known = m_known[4'(m_cnt + 1)];
                  end
               end else begin
                  m_mem[4'(m_cnt)] = ad_in; m_known[4'(m_cnt)] = 1'b1;
               end
               m_cnt++;
               if (frame_n) model_release();
               else if (m_cnt == DEPTH) begin
                  m_phase = PhStop; m_trdy = 1'b1; m_stop = 1'b0;
               end
            end
         end
         PhStop: if (frame_n) model_release();
         default: ;
      endcase
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("flags", {28'd0, trdy_n, devsel_n, stop_n, ad_oe},
            {28'd0, m_trdy, m_devsel, m_stop, m_oe});
      check("data_count", {28'd0, data_count}, 32'(m_cnt));
      if (m_out_known) check("ad_out", ad_out, m_out);
   endtask

   task automatic drive(input logic f, input logic i, input logic c, input logic [31:0] a);
      frame_n = f; irdy_n = i; cbe = c; ad_in = a;
   endtask

   initial begin
      for (int k = 0; k < DEPTH; k++) begin
         m_mem[k] = 32'd0; m_known[k] = 1'b0;
      end
      model_release();
      m_cnt = 0; m_out = 32'd0; m_out_known = 1'b0; m_read = 1'b0;

      reset = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 32'd0);
      step(); step();
      check("rst_flags", {28'd0, trdy_n, devsel_n, stop_n, ad_oe}, 32'hE);
      check("rst_count", {28'd0, data_count}, 32'd0);
      check("rst_ad_out", ad_out, 32'd0);
      reset = 1'b0;

      // Write 11,22,33; read them back; mismatched address; read with wait states.
      vecs.push_back(mk(0, 1, 0, 32'd1,  4'b0010, 4'd0, 1, 32'd0));
      vecs.push_back(mk(0, 0, 0, 32'd11, 4'b0010, 4'd1, 1, 32'd0));
      vecs.push_back(mk(0, 0, 0, 32'd22, 4'b0010, 4'd2, 1, 32'd0));
      vecs.push_back(mk(1, 0, 0, 32'd33, 4'b1110, 4'd3, 1, 32'd0));
      vecs.push_back(mk(0, 1, 1, 32'd1,  4'b1010, 4'd0, 1, 32'd0));
      vecs.push_back(mk(0, 0, 1, 32'd0,  4'b0011, 4'd0, 1, 32'd11));
      vecs.push_back(mk(0, 0, 1, 32'd0,  4'b0011, 4'd1, 1, 32'd22));
      vecs.push_back(mk(0, 0, 1, 32'd0,  4'b0011, 4'd2, 1, 32'd33));
      vecs.push_back(mk(1, 0, 1, 32'd0,  4'b1110, 4'd3, 0, 32'd0));
      vecs.push_back(mk(0, 1, 1, 32'd2,  4'b1110, 4'd3, 0, 32'd0));
      vecs.push_back(mk(0, 0, 1, 32'd0,  4'b1110, 4'd3, 0, 32'd0));
      vecs.push_back(mk(1, 0, 1, 32'd0,  4'b1110, 4'd3, 0, 32'd0));
      vecs.push_back(mk(1, 1, 1, 32'd0,  4'b1110, 4'd3, 0, 32'd0));
      vecs.push_back(mk(0, 1, 1, 32'd1,  4'b1010, 4'd0, 0, 32'd0));
      vecs.push_back(mk(0, 1, 1, 32'd0,  4'b0011, 4'd0, 1, 32'd11));
      vecs.push_back(mk(0, 1, 1, 32'd0,  4'b0011, 4'd0, 1, 32'd11));
      vecs.push_back(mk(0, 0, 1, 32'd0,  4'b0011, 4'd1, 1, 32'd22));
      vecs.push_back(mk(0, 1, 1, 32'd0,  4'b0011, 4'd1, 1, 32'd22));
      vecs.push_back(mk(0, 1, 1, 32'd0,  4'b0011, 4'd1, 1, 32'd22));
      vecs.push_back(mk(1, 0, 1, 32'd0,  4'b1110, 4'd2, 1, 32'd33));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].frame_n, vecs[i].irdy_n, vecs[i].cbe, vecs[i].ad);
         step();
         check($sformatf("vec%0d_flags", i), {28'd0, trdy_n, devsel_n, stop_n, ad_oe},
               {28'd0, vecs[i].exp_flags});
         check($sformatf("vec%0d_count", i), {28'd0, data_count}, {28'd0, vecs[i].exp_cnt});
         if (vecs[i].chk_out) check($sformatf("vec%0d_ad_out", i), ad_out, vecs[i].exp_out);
      end

      // Write burst of 12 with FRAME held low: target disconnects after word 10.
      drive(0, 1, 0, DEV);
      step();
      for (int i = 0; i < 12; i++) begin
         drive(0, 0, 0, 32'd100 + 32'(i));
         step();
         if (i == 9) begin
            check("exh_stop", {29'd0, trdy_n, devsel_n, stop_n}, 32'b100);
         end
      end
      check("exh_count", {28'd0, data_count}, 32'd10);
      check("exh_stop_held", {31'd0, stop_n}, 32'd0);
      drive(1, 1, 0, 32'd0);
      step();
      check("exh_release", {28'd0, trdy_n, devsel_n, stop_n, ad_oe}, 32'hE);

      // Read all 10 words back; last word has FRAME high at idx DEPTH-1.
      drive(0, 1, 1, DEV);
      step();
      drive(0, 1, 1, 32'd0);
      step();
      for (int i = 0; i < DEPTH; i++) begin
         check($sformatf("rdback%0d", i), ad_out, 32'd100 + 32'(i));
         drive(logic'(i == DEPTH - 1), 0, 1, 32'd0);
         step();
      end
      check("rdback_end", {28'd0, trdy_n, devsel_n, stop_n, ad_oe}, 32'hE);

      // Reset in the middle of a write burst; the write on the reset edge is dropped.
      drive(0, 1, 0, DEV);
      step();
      drive(0, 0, 0, 32'd200);
      step();
      drive(0, 0, 0, 32'd201);
      step();
      drive(0, 0, 0, 32'd202);
      reset = 1'b1;
      step();
      check("midrst_flags", {28'd0, trdy_n, devsel_n, stop_n, ad_oe}, 32'hE);
      check("midrst_count", {28'd0, data_count}, 32'd0);
      check("midrst_ad_out", ad_out, 32'd0);
      reset = 1'b0;
      drive(1, 1, 0, 32'd0);
      step();
      drive(0, 1, 1, DEV);
      step();
      drive(0, 1, 1, 32'd0);
      step();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("postrst%0d", i), ad_out, (i == 0) ? 32'd200 : (i == 1) ? 32'd201 : 32'd102);
         drive(logic'(i == 2), 0, 1, 32'd0);
         step();
      end

      // Randomized transactions against the model.
      for (int t = 0; t < 300; t++) begin : g_tr
         int          len;
         int          done_words;
         logic [31:0] a;
         repeat ($urandom_range(0, 2)) begin
            drive(1, 1, 0, $urandom);
            step();
         end
         a = ($urandom_range(0, 3) != 0) ? DEV : ($urandom | 32'h100);
         len = $urandom_range(1, 13);
         done_words = 0;
         drive(0, 1, logic'($urandom_range(0, 1)), a);
         step();
         for (int c = 0; c < 60 && m_phase != PhIdle; c++) begin
            if (m_phase == PhIgnore || m_phase == PhStop) begin
               frame_n = logic'($urandom_range(0, 1));
               irdy_n  = logic'($urandom_range(0, 1));
            end else if ($urandom_range(0, 29) == 0) begin
               frame_n = 1'b1; irdy_n = 1'b1;
            end else if ($urandom_range(0, 3) == 0) begin
               frame_n = 1'b0; irdy_n = 1'b1;
            end else begin
               irdy_n  = 1'b0;
               frame_n = logic'(done_words >= len - 1);
            end
            ad_in = $urandom;
            reset = logic'($urandom_range(0, 199) == 0);
            if (!irdy_n && !m_trdy && !reset) done_words++;
            step();
            reset = 1'b0;
         end
         drive(1, 1, 0, $urandom);
         for (int c = 0; c < 3 && m_phase != PhIdle; c++) step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
